// File: rtl/store_buf_pkg.sv
// Shared types and defaults for the store buffer and its address comparator.
package store_buf_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        DRAIN
    } owner_e;

endpackage

// File: rtl/store_buf_match.sv
// Compares a load address against every valid queued store and reports the youngest match.
module store_buf_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    i_addr [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PW-1:0]    i_head,
    input  logic [AW-1:0]    i_cpu_addr,
    output logic             o_hit,
    output logic [PW-1:0]    o_idx
);

    logic [PW-1:0] w_slot;

    // Walk from oldest (head) to youngest so the last match seen wins.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = i_head;
        w_slot = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = i_head + PW'(k);
            if (i_valid[w_slot] && (i_addr[w_slot] == i_cpu_addr)) begin
                o_hit = 1'b1;
                o_idx = w_slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer owning the single dataMemory port; stores retire on spare bus cycles.
// Define STORE_BUF_FWD_EN for youngest-match load forwarding; otherwise matching loads stall.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          flush,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_valid;
    logic             w_hit;
    logic [PW-1:0]    w_idx;
    logic             w_full;
    logic             w_load_go;
    logic             w_push;
    logic             w_pop;
    owner_e           w_owner;

    // Slot i is live when its distance from head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = (CW'(PW'(PW'(i) - r_head)) < r_count);
        end
    end

    store_buf_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_match (
        .i_addr     (r_addr),
        .i_valid    (w_valid),
        .i_head     (r_head),
        .i_cpu_addr (cpu_addr),
        .o_hit      (w_hit),
`ifdef STORE_BUF_FWD_EN
        .o_idx      (w_idx)
`else
        .o_idx      ()
`endif
    );

`ifndef STORE_BUF_FWD_EN
    assign w_idx = '0;
`endif

    assign w_full = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);

`ifdef STORE_BUF_FWD_EN
    assign w_load_go = cpu_re;
`else
    assign w_load_go = cpu_re && !w_hit;
`endif

    always_comb begin
        w_owner = NONE;
        if (w_load_go) begin
            w_owner = LOAD;
        end else if (!empty && ((!cpu_we && !cpu_re) || flush ||
                                (cpu_we && w_full) || (cpu_re && w_hit))) begin
            w_owner = DRAIN;
        end
    end

    // A simultaneous store and load is a protocol error; the store is dropped.
    assign w_push = cpu_we && !cpu_re && !w_full;
    assign w_pop  = (w_owner == DRAIN);

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_owner)
            LOAD: begin
                mem_re   = 1'b1;
                mem_addr = cpu_addr;
            end
            DRAIN: begin
                mem_we    = 1'b1;
                mem_addr  = r_addr[r_head];
                mem_wdata = r_data[r_head];
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_rdata = '0;
        cpu_stall = cpu_we && !cpu_re && w_full;
        if (cpu_re) begin
`ifdef STORE_BUF_FWD_EN
            cpu_rdata = w_hit ? r_data[w_idx] : mem_rdata;
`else
            cpu_rdata = mem_rdata;
            cpu_stall = w_hit;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry payload is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= cpu_addr;
            r_data[r_tail] <= cpu_wdata;
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the CPU's load/store datapath and `dataMemory`. Stores are queued in a small FIFO and retired to memory on idle bus cycles, so a store cycle never carries a memory write. Loads are served from memory, with youngest-match forwarding from queued stores. The block owns the single memory port (`address`, `writeData`, `memWrite`, `memRead`, `readData`) and presents a stall-capable load/store interface to the CPU.

## Interface
- `DEPTH`, 4: number of queued stores; power of two, minimum 2.
- `AW`, 32: address width; full-width compare, word-indexed as `dataMemory` expects.
- `DW`, 32: data width.
- `clk`  in  1  rising-edge clock, shared with `dataMemory`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_we`  in  1  store request this cycle.
- `cpu_re`  in  1  load request this cycle.
- `cpu_addr`  in  AW  load/store address.
- `cpu_wdata`  in  DW  store data.
- `cpu_rdata`  out  DW  load data, combinational; 0 when `cpu_re`=0.
- `cpu_stall`  out  1  CPU must hold its request and retry next cycle.
- `flush`  in  1  level request: drain every cycle until empty.
- `empty`  out  1  no stores queued.
- `mem_addr`  out  AW  to `dataMemory.address`.
- `mem_wdata`  out  DW  to `dataMemory.writeData`.
- `mem_we`  out  1  to `dataMemory.memWrite`.
- `mem_re`  out  1  to `dataMemory.memRead`.
- `mem_rdata`  in  DW  from `dataMemory.readData`.

## Operation
- State: circular FIFO of {addr, data}, head/tail pointers, count 0..DEPTH. Reset clears all three; `empty`=1.
- Port arbitration per cycle, first match wins:
  1. Load: `mem_re`=1, `mem_addr`=`cpu_addr`, `mem_we`=0. No drain.
  2. Drain: when count>0 and any of: idle cycle (`cpu_we`=`cpu_re`=0), `flush`=1, or store while full. Drives `mem_we`=1 with head entry; head is popped at the edge.
  3. Otherwise `mem_we`=`mem_re`=0 and `mem_addr`=0.
- Store, not full: enqueue at tail at the edge; `cpu_stall`=0.
- Store, full: `cpu_stall`=1; head drains this cycle. The retried store is accepted next cycle.
- Load forwarding: compare `cpu_addr` with all valid entries. On one or more matches, `cpu_rdata` is the youngest match's data; otherwise it is `mem_rdata`. `cpu_stall`=0.
- Two stores to the same address both stay queued and drain in order. Memory ends with the younger value.
- `cpu_we` and `cpu_re` together is a protocol error. The load is serviced, the store is dropped, and the bench asserts this never occurs.
- Async reset mid-operation discards queued stores. No partial write occurs, because `mem_we` falls with reset.
- `flush` with a load active: the load wins the port and draining resumes next cycle.

## Timing
- Load latency 0: data is valid in the same cycle, combinational through forwarding mux or memory.
- A store becomes memory-visible at the posedge of its drain cycle. That is at least 1 cycle after enqueue, unbounded under continuous traffic.
- `empty` and `cpu_stall` are combinational from count and requests. `cpu_stall` is never asserted for loads when forwarding is compiled in.
- Reset values: `cpu_stall`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0, `empty`=1.

## Configuration
- `STORE_BUF_FWD_EN` defined: youngest-match forwarding as above.
- Undefined: a load matching any queued entry sets `cpu_stall`=1. That cycle drains the head instead of loading. Stall repeats until no entry matches, then the load reads memory. Non-matching loads are unaffected.

## Structure
- `store_buf_pkg`: `DEPTH`/`AW`/`DW` defaults, `PTR_W`=$clog2(DEPTH), entry struct {addr, data}, port-owner enum {NONE, LOAD, DRAIN}.
- Sub-module `store_buf_match`: combinational comparator. Takes the entry array, valid mask, head pointer and `cpu_addr`. Returns hit and youngest-match index.
- Top holds the FIFO, arbitration and output muxes.

## Test plan
- Reset, then idle: `empty`=1, all outputs 0. Toggle `rst_n` low mid-drain: `mem_we` drops immediately and count returns to 0.
- Stores 0x10←0xAAAA, 0x11←0xBBBB back-to-back, then one idle cycle: 0x10 is written. After a second idle cycle 0x11 is written and `empty`=1.
- Fill 4 stores with no idle cycles, then a 5th to 0x20: `cpu_stall`=1 for 1 cycle, the head drains, the 5th is accepted next cycle, count=4.
- Store 0x30←1, store 0x30←2, then load 0x30: `cpu_rdata`=2 with `STORE_BUF_FWD_EN`. Without it, stall for 2 cycles, then 2 is read from memory.
- Load 0x40 (unbuffered, memory holds 0x55) with 3 entries queued: `cpu_rdata`=0x55, no drain that cycle, count stays 3.
- `flush` held with 3 queued: `mem_we`=1 for 3 consecutive cycles, `empty`=1 on the 4th, and memory holds all 3 values.
